// File: rtl/cpu_pkg.sv
// Shared opcode, funct and ALU-control encodings for the MIPS-subset pipeline,
// plus the control-bundle type and the data-memory power-on image.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_XOR = 4'b0011;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [3:0] aluc;
    logic       aluimm;
    logic       regrt;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Word loaded into each data-memory location on reset.
  function automatic logic [31:0] dm_init_word(input int unsigned idx);
    logic [31:0] w;
    case (idx)
      0:       w = 32'hA00000AA;
      1:       w = 32'h10000011;
      2:       w = 32'h20000022;
      3:       w = 32'h30000033;
      4:       w = 32'h40000044;
      5:       w = 32'h50000055;
      6:       w = 32'h60000066;
      7:       w = 32'h70000077;
      8:       w = 32'h80000088;
      9:       w = 32'h90000099;
      default: w = 32'h00000000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-addressed data memory: asynchronous read, synchronous write, and a
// synchronous reset that reloads the fixed initial image (reset beats write).
module dm_ram
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [DATA_W-1:0] rdata
);

  localparam int AW = $clog2(DM_DEPTH);

  logic [DATA_W-1:0] mem_q [DM_DEPTH];
  logic [DATA_W-1:0] mem_d [DM_DEPTH];
  logic [AW-1:0]     idx;

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign idx = addr[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  assign rdata = mem_q[idx];

  always_comb begin
    mem_d = mem_q;
    if (rst) begin
      for (int i = 0; i < DM_DEPTH; i++) begin
        mem_d[i] = DATA_W'(dm_init_word(i));
      end
    end else if (we) begin
      mem_d[idx] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cpu_ctrl_mem.sv
// Pipeline support block: IF-stage PC incrementer, ID-stage control decoder
// (both combinational) and the MEM-stage data memory.
module cpu_ctrl_mem
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DM_DEPTH = 32,
  parameter int PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  output logic [31:0]       pc_next,
  input  logic [31:0]       instr,
  output logic              wreg,
  output logic              m2reg,
  output logic              wmem,
  output logic [3:0]        aluc,
  output logic              aluimm,
  output logic              regrt,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_we,
  output logic [DATA_W-1:0] dm_rdata
);

  assign pc_next = pc_in + 32'(PC_INC);

  logic [5:0] op;
  logic [5:0] fn;
  ctrl_t      ctrl;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  // Register fields are consumed by the register file, not by this decoder.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        ctrl.wreg = 1'b1;
        case (fn)
          FN_ADD:  ctrl.aluc = ALUC_ADD;
          FN_SUB:  ctrl.aluc = ALUC_SUB;
          FN_AND:  ctrl.aluc = ALUC_AND;
          FN_OR:   ctrl.aluc = ALUC_OR;
          FN_XOR:  ctrl.aluc = ALUC_XOR;
          FN_SLT:  ctrl.aluc = ALUC_SLT;
          default: ctrl = CTRL_NOP;
        endcase
      end
      OP_LW: begin
        ctrl.wreg   = 1'b1;
        ctrl.m2reg  = 1'b1;
        ctrl.aluimm = 1'b1;
        ctrl.regrt  = 1'b1;
        ctrl.aluc   = ALUC_ADD;
      end
      OP_SW: begin
        ctrl.wmem   = 1'b1;
        ctrl.aluimm = 1'b1;
        ctrl.regrt  = 1'b1;
        ctrl.aluc   = ALUC_ADD;
      end
      OP_ADDI: begin
        ctrl.wreg   = 1'b1;
        ctrl.aluimm = 1'b1;
        ctrl.regrt  = 1'b1;
        ctrl.aluc   = ALUC_ADD;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  assign wreg   = ctrl.wreg;
  assign m2reg  = ctrl.m2reg;
  assign wmem   = ctrl.wmem;
  assign aluc   = ctrl.aluc;
  assign aluimm = ctrl.aluimm;
  assign regrt  = ctrl.regrt;

  dm_ram #(
    .DATA_W   (DATA_W),
    .DM_DEPTH (DM_DEPTH)
  ) u_dm_ram (
    .clk   (clk),
    .rst   (rst),
    .addr  (dm_addr),
    .wdata (dm_wdata),
    .we    (dm_we),
    .rdata (dm_rdata)
  );

endmodule

// File: tb/tb_cpu_ctrl_mem.sv
// Scoreboard bench for cpu_ctrl_mem: directed points plus randomized traffic,
// checked against a table-driven reference of the adder, decoder and memory.
module tb_cpu_ctrl_mem;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic        wreg, m2reg, wmem, aluimm, regrt;
  logic [3:0]  aluc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;

  cpu_ctrl_mem dut (
    .clk      (clk),
    .rst      (rst),
    .pc_in    (pc_in),
    .pc_next  (pc_next),
    .instr    (instr),
    .wreg     (wreg),
    .m2reg    (m2reg),
    .wmem     (wmem),
    .aluc     (aluc),
    .aluimm   (aluimm),
    .regrt    (regrt),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_rdata (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 pc_next, 1 ctrl bundle, 2 dm_rdata
    logic [31:0] exp_v;
    logic [31:0] stim;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] ref_mem [32];
  bit          ref_valid = 0;

  localparam logic [5:0] RFN   [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
  localparam logic [3:0] RALUC [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd7};

  function automatic logic [31:0] ref_init(input int i);
    if (i == 0) return 32'hA00000AA;
    if (i <= 9) return i * 32'h10000011;
    return 32'h0;
  endfunction

  // {wreg, m2reg, wmem, aluimm, regrt, aluc[3:0]}
  function automatic logic [8:0] ref_ctrl(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'd0) begin
      for (int k = 0; k < 6; k++)
        if (fn == RFN[k]) return {5'b10000, RALUC[k]};
      return 9'd0;
    end
    if (op == 6'h23) return {5'b11011, 4'd2};
    if (op == 6'h2B) return {5'b00111, 4'd2};
    if (op == 6'h08) return {5'b10011, 4'd2};
    return 9'd0;
  endfunction

  task automatic drive(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] addr, input logic [31:0] wd, input logic we);
    exp_t e;
    int   wi;
    @(posedge clk);
    #1;
    rst = r; pc_in = pc; instr = ins; dm_addr = addr; dm_wdata = wd; dm_we = we;
    e.kind = 0; e.exp_v = pc + 32'd4; e.stim = pc; q.push_back(e);
    e.kind = 1; e.exp_v = {23'd0, ref_ctrl(ins)}; e.stim = ins; q.push_back(e);
    wi = int'((addr / 4) % 32);
    if (ref_valid) begin
      e.kind = 2; e.exp_v = ref_mem[wi]; e.stim = addr; q.push_back(e);
    end
    // Model the effect of the upcoming edge.
    if (r) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = ref_init(i);
      ref_valid = 1;
    end else if (we && ref_valid) begin
      ref_mem[wi] = wd;
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      string       nm;
      e = q.pop_front();
      case (e.kind)
        0:       begin act = pc_next; nm = "pc_next"; end
        1:       begin act = {23'd0, wreg, m2reg, wmem, aluimm, regrt, aluc}; nm = "ctrl"; end
        default: begin act = dm_rdata; nm = "dm_rdata"; end
      endcase
      n_tests++;
      if (act !== e.exp_v) begin
        n_fail++;
        $display("FAIL %s stim=%h actual=%h expected=%h", nm, e.stim, act, e.exp_v);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0]  op;
    logic [5:0]  fn;
    ins = $urandom;
    case ($urandom_range(0, 4))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2B;
      3: op = 6'h08;
      default: op = 6'($urandom);
    endcase
    if ($urandom_range(0, 9) < 7) fn = RFN[$urandom_range(0, 5)];
    else fn = 6'($urandom);
    ins[31:26] = op;
    ins[5:0]   = fn;
    return ins;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_in = '0; instr = '0; dm_addr = '0; dm_wdata = '0; dm_we = 1'b0;
    // Reset with a colliding write that must be dropped.
    drive(1'b1, 32'h0000_0100, 32'h8C22_0000, 32'h0, 32'h1234_5678, 1'b1);
    drive(1'b0, 32'h0000_0100, 32'h8C22_0000, 32'h00, 32'h0, 1'b0);
    drive(1'b0, 32'hFFFF_FFFC, 32'hAC22_0004, 32'h04, 32'h0, 1'b0);
    drive(1'b0, 32'h0000_0000, 32'h0022_1820, 32'h26, 32'h0, 1'b0);
    drive(1'b0, 32'h0000_0008, 32'h0022_1822, 32'h28, 32'h0, 1'b0);
    drive(1'b0, 32'h0000_000C, 32'h0022_1824, 32'h14, 32'hDEAD_BEEF, 1'b1);
    drive(1'b0, 32'h0000_0010, 32'h0022_1825, 32'h14, 32'h0, 1'b0);
    drive(1'b0, 32'h0000_0014, 32'h0022_1826, 32'h94, 32'h0, 1'b0);
    drive(1'b0, 32'h0000_0018, 32'h0022_182A, 32'h14, 32'h0, 1'b0);
    drive(1'b0, 32'h0000_001C, 32'h0022_183F, 32'h00, 32'h0, 1'b0);
    drive(1'b0, 32'h0000_0020, 32'h2022_0005, 32'h00, 32'h0, 1'b0);
    drive(1'b0, 32'h0000_0024, 32'hFC00_0000, 32'h00, 32'h0, 1'b0);
    drive(1'b1, 32'h0000_0028, 32'h0000_0000, 32'h00, 32'h1234_5678, 1'b1);
    drive(1'b0, 32'h0000_002C, 32'h0000_0000, 32'h00, 32'h0, 1'b0);
    drive(1'b0, 32'h0000_0030, 32'h0000_0000, 32'h14, 32'h0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [31:0] pc;
      a  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom;
      pc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 39) == 0, pc, rand_instr(), a, $urandom,
            $urandom_range(0, 1) == 1);
    end

    @(posedge clk);
    #1;
    dm_we = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
